// File: rtl/modem_cmult_pipe_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : modem_cmult_pipe_if
// Purpose  : Sample/result bundle for the pipelined complex multiplier.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
interface modem_cmult_pipe_if #(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 16,
  parameter int CNT_W  = 16
);
  logic                     i_valid;
  logic                     i_conj;
  logic signed [DATA_W-1:0] i_a_i;
  logic signed [DATA_W-1:0] i_a_q;
  logic signed [DATA_W-1:0] i_b_i;
  logic signed [DATA_W-1:0] i_b_q;
  logic                     i_sat_clr;
  logic                     o_valid;
  logic signed [OUT_W-1:0]  o_c_i;
  logic signed [OUT_W-1:0]  o_c_q;
  logic                     o_sat;
  logic [CNT_W-1:0]         o_sat_cnt;

  modport master (
    output i_valid, i_conj, i_a_i, i_a_q, i_b_i, i_b_q, i_sat_clr,
    input  o_valid, o_c_i, o_c_q, o_sat, o_sat_cnt
  );

  modport slave (
    input  i_valid, i_conj, i_a_i, i_a_q, i_b_i, i_b_q, i_sat_clr,
    output o_valid, o_c_i, o_c_q, o_sat, o_sat_cnt
  );
endinterface
`default_nettype wire

// File: rtl/modem_cmult_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : modem_cmult_pipe
// Purpose  : 4-stage complex multiplier (a*b or a*conj(b)) with rounding,
//            saturation and a sticky saturation counter.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module modem_cmult_pipe #(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 15,
  parameter int CNT_W  = 16
) (
  input logic               clk,
  input logic               reset,
  modem_cmult_pipe_if.slave bus
);
  localparam int PW = 2 * DATA_W;
  localparam int SW = PW + 1;
  localparam int RW = SW + 1;  // headroom for the rounding bias
  localparam logic signed [RW-1:0] C_MAX = {{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [RW-1:0] C_MIN = {{(RW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]     C_CNT_MAX = {CNT_W{1'b1}};

  logic                     r1_valid, r1_conj;
  logic signed [DATA_W-1:0] r1_a_i, r1_a_q, r1_b_i, r1_b_q;
  logic                     r2_valid, r2_conj;
  logic signed [PW-1:0]     r2_p_ii, r2_p_qq, r2_p_qi, r2_p_iq;
  logic                     r3_valid;
  logic signed [SW-1:0]     r3_s_i, r3_s_q;
  logic                     r4_valid, r_sat;
  logic signed [OUT_W-1:0]  r_c_i, r_c_q;
  logic [CNT_W-1:0]         r_sat_cnt;
  logic signed [RW-1:0]     w_rnd_i, w_rnd_q;
  logic signed [OUT_W-1:0]  w_c_i, w_c_q;
  logic                     w_sat_i, w_sat_q, w_sat;

  // Data registers load only with their valid, so idle inputs never disturb them.
  always_ff @(posedge clk) begin
    if (reset) begin
      r1_valid <= 1'b0;
      r2_valid <= 1'b0;
      r3_valid <= 1'b0;
    end else begin
      r1_valid <= bus.i_valid;
      r2_valid <= r1_valid;
      r3_valid <= r2_valid;
    end
    if (bus.i_valid) begin
      r1_conj <= bus.i_conj;
      r1_a_i  <= bus.i_a_i;
      r1_a_q  <= bus.i_a_q;
      r1_b_i  <= bus.i_b_i;
      r1_b_q  <= bus.i_b_q;
    end
    if (r1_valid) begin
      r2_conj <= r1_conj;
      r2_p_ii <= r1_a_i * r1_b_i;
      r2_p_qq <= r1_a_q * r1_b_q;
      r2_p_qi <= r1_a_q * r1_b_i;
      r2_p_iq <= r1_a_i * r1_b_q;
    end
    if (r2_valid) begin
      r3_s_i <= r2_conj ? SW'(r2_p_ii) + SW'(r2_p_qq) : SW'(r2_p_ii) - SW'(r2_p_qq);
      r3_s_q <= r2_conj ? SW'(r2_p_qi) - SW'(r2_p_iq) : SW'(r2_p_qi) + SW'(r2_p_iq);
    end
  end

  generate
    if (SHIFT == 0) begin : g_pass
      assign w_rnd_i = RW'(r3_s_i);
      assign w_rnd_q = RW'(r3_s_q);
    end else begin : g_round
      localparam logic signed [RW-1:0] C_HALF    = RW'(1) <<< (SHIFT - 1);
      localparam logic signed [RW-1:0] C_HALF_M1 = C_HALF - RW'(1);
      logic signed [RW-1:0] w_bias_i, w_bias_q;
      // Negative sums take half-1 so the arithmetic shift rounds -0.5 to -1.
      assign w_bias_i = r3_s_i[SW-1] ? C_HALF_M1 : C_HALF;
      assign w_bias_q = r3_s_q[SW-1] ? C_HALF_M1 : C_HALF;
      assign w_rnd_i  = (RW'(r3_s_i) + w_bias_i) >>> SHIFT;
      assign w_rnd_q  = (RW'(r3_s_q) + w_bias_q) >>> SHIFT;
    end
  endgenerate

  always_comb begin
    w_sat_i = 1'b0;
    w_sat_q = 1'b0;
    w_c_i   = w_rnd_i[OUT_W-1:0];
    w_c_q   = w_rnd_q[OUT_W-1:0];
    if (w_rnd_i > C_MAX) begin
      w_c_i   = C_MAX[OUT_W-1:0];
      w_sat_i = 1'b1;
    end else if (w_rnd_i < C_MIN) begin
      w_c_i   = C_MIN[OUT_W-1:0];
      w_sat_i = 1'b1;
    end
    if (w_rnd_q > C_MAX) begin
      w_c_q   = C_MAX[OUT_W-1:0];
      w_sat_q = 1'b1;
    end else if (w_rnd_q < C_MIN) begin
      w_c_q   = C_MIN[OUT_W-1:0];
      w_sat_q = 1'b1;
    end
  end

  assign w_sat = w_sat_i | w_sat_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r4_valid  <= 1'b0;
      r_c_i     <= '0;
      r_c_q     <= '0;
      r_sat     <= 1'b0;
      r_sat_cnt <= '0;
    end else begin
      r4_valid <= r3_valid;
      if (r3_valid) begin
        r_c_i <= w_c_i;
        r_c_q <= w_c_q;
        r_sat <= w_sat;
      end
      // Counter moves together with the result it counts; clear wins.
      if (bus.i_sat_clr)
        r_sat_cnt <= '0;
      else if (r3_valid && w_sat && (r_sat_cnt != C_CNT_MAX))
        r_sat_cnt <= r_sat_cnt + CNT_W'(1);
    end
  end

  assign bus.o_valid   = r4_valid;
  assign bus.o_c_i     = r_c_i;
  assign bus.o_c_q     = r_c_q;
  assign bus.o_sat     = r_sat;
  assign bus.o_sat_cnt = r_sat_cnt;
endmodule
`default_nettype wire

// File: tb/tb_modem_cmult_pipe.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_modem_cmult_pipe
// Purpose  : Self-checking bench for modem_cmult_pipe against an arithmetic model.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_modem_cmult_pipe;
  localparam int DATA_W = 16;
  localparam int OUT_W  = 16;
  localparam int SHIFT  = 15;
  localparam int CNT_W  = 16;
  localparam int NRND   = 240;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   exp_cnt;
  int   last_ci, last_cq, last_sat;

  modem_cmult_pipe_if #(.DATA_W(DATA_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) bus ();

  modem_cmult_pipe #(
    .DATA_W(DATA_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .CNT_W(CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog expired got timeout want finish");
    $fatal(1);
  end

  // Round |s|/2^SHIFT to nearest with halves going up, restore sign, then clamp.
  function automatic void rnd_sat(input longint s, output int c, output int sat);
    longint scale, mag, r, hi, lo;
    scale = longint'(1) <<< SHIFT;
    hi    = (longint'(1) <<< (OUT_W - 1)) - 1;
    lo    = -(longint'(1) <<< (OUT_W - 1));
    mag   = (s < 0) ? -s : s;
    r     = (2 * mag + scale) / (2 * scale);
    if (s < 0) r = -r;
    sat = 0;
    if (r > hi) begin r = hi; sat = 1; end
    if (r < lo) begin r = lo; sat = 1; end
    c = int'(r);
  endfunction

  function automatic void model(input int ai, aq, bi, bq, cj,
                                output int ci, cq, sat);
    longint sgn, si, sq;
    int     s1, s2;
    sgn = (cj != 0) ? 1 : -1;
    si  = longint'(ai) * bi + sgn * (longint'(aq) * bq);
    sq  = longint'(aq) * bi - sgn * (longint'(ai) * bq);
    rnd_sat(si, ci, s1);
    rnd_sat(sq, cq, s2);
    sat = s1 | s2;
  endfunction

  function automatic int rnd16();
    logic signed [15:0] t;
    t = 16'($urandom);
    case ($urandom_range(0, 7))
      0: t = -16'sd32768;
      1: t = 16'sd32767;
      default: ;
    endcase
    return int'(t);
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input int v, cj, ai, aq, bi, bq, clr);
    bus.i_valid   = 1'(v);
    bus.i_conj    = 1'(cj);
    bus.i_a_i     = DATA_W'(ai);
    bus.i_a_q     = DATA_W'(aq);
    bus.i_b_i     = DATA_W'(bi);
    bus.i_b_q     = DATA_W'(bq);
    bus.i_sat_clr = 1'(clr);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1, 1, rnd16(), rnd16(), rnd16(), rnd16(), 0);
    step();
    step();
    step();
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL reset_o_valid got %b want 0", bus.o_valid); end
    checks++; if (int'(bus.o_c_i) !== 0) begin errors++; $display("FAIL reset_o_c_i got %0d want 0", bus.o_c_i); end
    checks++; if (int'(bus.o_c_q) !== 0) begin errors++; $display("FAIL reset_o_c_q got %0d want 0", bus.o_c_q); end
    checks++; if (bus.o_sat !== 1'b0) begin errors++; $display("FAIL reset_o_sat got %b want 0", bus.o_sat); end
    checks++; if (int'(bus.o_sat_cnt) !== 0) begin errors++; $display("FAIL reset_o_sat_cnt got %0d want 0", bus.o_sat_cnt); end
    drive(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    exp_cnt = 0; last_ci = 0; last_cq = 0; last_sat = 0;
  endtask

  task automatic test_directed();
    int v[10]   = '{1, 1, 1, 1, 1, 0, 1, 1, 1, 1};
    int cj[10]  = '{0, 1, 0, 0, 0, 1, 0, 0, 0, 0};
    int ai[10]  = '{16384, 0, 0, 1, -1, -32768, 3, -3, 0, -32768};
    int aq[10]  = '{0, 16384, 16384, 0, 0, -32768, 0, 0, -32768, 32767};
    int bi[10]  = '{16384, 0, 0, 16384, 16384, -32768, 16384, 16384, -32768, 32767};
    int bq[10]  = '{16384, 16384, 16384, 0, 0, -32768, 0, 0, 0, 32767};
    int eci[10] = '{8192, 8192, -8192, 1, -1, 0, 2, -2, 0, -32768};
    int ecq[10] = '{8192, 0, 0, 0, 0, 0, 0, 0, 32767, -1};
    int es[10]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    for (int k = 0; k < 14; k++) begin
      if (k < 10) drive(v[k], cj[k], ai[k], aq[k], bi[k], bq[k], 0);
      else        drive(0, 0, 0, 0, 0, 0, 0);
      step();
      if (k >= 3) begin
        int j, ev;
        j  = k - 3;
        ev = (j < 10) ? v[j] : 0;
        if (ev != 0) begin
          last_ci = eci[j]; last_cq = ecq[j]; last_sat = es[j];
          if (es[j] != 0 && exp_cnt < 65535) exp_cnt++;
        end
        checks++; if (bus.o_valid !== 1'(ev)) begin errors++; $display("FAIL dir_valid[%0d] got %b want %0d", j, bus.o_valid, ev); end
        checks++; if (int'(bus.o_c_i) !== last_ci) begin errors++; $display("FAIL dir_c_i[%0d] got %0d want %0d", j, bus.o_c_i, last_ci); end
        checks++; if (int'(bus.o_c_q) !== last_cq) begin errors++; $display("FAIL dir_c_q[%0d] got %0d want %0d", j, bus.o_c_q, last_cq); end
        checks++; if (bus.o_sat !== 1'(last_sat)) begin errors++; $display("FAIL dir_sat[%0d] got %b want %0d", j, bus.o_sat, last_sat); end
        checks++; if (int'(bus.o_sat_cnt) !== exp_cnt) begin errors++; $display("FAIL dir_cnt[%0d] got %0d want %0d", j, bus.o_sat_cnt, exp_cnt); end
      end
    end
  endtask

  task automatic test_back_to_back_random();
    int v[NRND], cj[NRND], ai[NRND], aq[NRND], bi[NRND], bq[NRND];
    int eci[NRND], ecq[NRND], es[NRND];
    for (int n = 0; n < NRND; n++) begin
      v[n]  = ($urandom_range(0, 3) != 0) ? 1 : 0;
      cj[n] = int'($urandom_range(0, 1));
      ai[n] = rnd16(); aq[n] = rnd16(); bi[n] = rnd16(); bq[n] = rnd16();
      model(ai[n], aq[n], bi[n], bq[n], cj[n], eci[n], ecq[n], es[n]);
    end
    for (int k = 0; k < NRND + 4; k++) begin
      if (k < NRND) drive(v[k], cj[k], ai[k], aq[k], bi[k], bq[k], 0);
      else          drive(0, 1, rnd16(), rnd16(), rnd16(), rnd16(), 0);
      step();
      if (k >= 3) begin
        int j, ev;
        j  = k - 3;
        ev = (j < NRND) ? v[j] : 0;
        if (ev != 0) begin
          last_ci = eci[j]; last_cq = ecq[j]; last_sat = es[j];
          if (es[j] != 0 && exp_cnt < 65535) exp_cnt++;
        end
        checks++; if (bus.o_valid !== 1'(ev)) begin errors++; $display("FAIL rnd_valid[%0d] got %b want %0d", j, bus.o_valid, ev); end
        checks++; if (int'(bus.o_c_i) !== last_ci) begin errors++; $display("FAIL rnd_c_i[%0d] got %0d want %0d", j, bus.o_c_i, last_ci); end
        checks++; if (int'(bus.o_c_q) !== last_cq) begin errors++; $display("FAIL rnd_c_q[%0d] got %0d want %0d", j, bus.o_c_q, last_cq); end
        checks++; if (bus.o_sat !== 1'(last_sat)) begin errors++; $display("FAIL rnd_sat[%0d] got %b want %0d", j, bus.o_sat, last_sat); end
        checks++; if (int'(bus.o_sat_cnt) !== exp_cnt) begin errors++; $display("FAIL rnd_cnt[%0d] got %0d want %0d", j, bus.o_sat_cnt, exp_cnt); end
      end
    end
  endtask

  task automatic test_sat_counter();
    drive(0, 0, 0, 0, 0, 0, 1);
    step();
    exp_cnt = 0;
    checks++; if (int'(bus.o_sat_cnt) !== 0) begin errors++; $display("FAIL cnt_clear got %0d want 0", bus.o_sat_cnt); end
    for (int k = 0; k < 70005; k++) begin
      drive((k < 70001) ? 1 : 0, 0, -32768, 0, -32768, 0, 0);
      step();
      if (k == 3) begin
        checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("FAIL sat_valid got %b want 1", bus.o_valid); end
        checks++; if (int'(bus.o_c_i) !== 32767) begin errors++; $display("FAIL sat_c_i got %0d want 32767", bus.o_c_i); end
        checks++; if (int'(bus.o_c_q) !== 0) begin errors++; $display("FAIL sat_c_q got %0d want 0", bus.o_c_q); end
        checks++; if (bus.o_sat !== 1'b1) begin errors++; $display("FAIL sat_flag got %b want 1", bus.o_sat); end
        checks++; if (int'(bus.o_sat_cnt) !== 1) begin errors++; $display("FAIL sat_cnt_first got %0d want 1", bus.o_sat_cnt); end
      end
      if (k == 65536) begin
        checks++; if (int'(bus.o_sat_cnt) !== 65534) begin errors++; $display("FAIL sat_cnt_near got %0d want 65534", bus.o_sat_cnt); end
      end
    end
    checks++; if (int'(bus.o_sat_cnt) !== 65535) begin errors++; $display("FAIL sat_cnt_hold got %0d want 65535", bus.o_sat_cnt); end
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL sat_drain_valid got %b want 0", bus.o_valid); end
    exp_cnt = 65535; last_ci = 32767; last_cq = 0; last_sat = 1;
  endtask

  task automatic test_sat_clr();
    for (int k = 0; k < 6; k++) begin
      drive((k < 2) ? 1 : 0, 0, -32768, 0, -32768, 0, (k == 3) ? 1 : 0);
      step();
      if (k == 3) begin
        checks++; if (bus.o_sat !== 1'b1 || bus.o_valid !== 1'b1) begin errors++; $display("FAIL clr_result got v=%b s=%b want v=1 s=1", bus.o_valid, bus.o_sat); end
        checks++; if (int'(bus.o_sat_cnt) !== 0) begin errors++; $display("FAIL clr_priority got %0d want 0", bus.o_sat_cnt); end
      end
      if (k == 4) begin
        checks++; if (int'(bus.o_sat_cnt) !== 1) begin errors++; $display("FAIL clr_recount got %0d want 1", bus.o_sat_cnt); end
      end
    end
    exp_cnt = 1;
  endtask

  task automatic test_midstream_reset();
    for (int k = 0; k < 9; k++) begin
      reset = (k == 3) ? 1'b1 : 1'b0;
      if (k < 3)       drive(1, int'($urandom_range(0, 1)), rnd16(), rnd16(), rnd16(), rnd16(), 0);
      else if (k == 4) drive(1, 0, 16384, 0, 16384, 16384, 0);
      else             drive(0, 1, rnd16(), rnd16(), rnd16(), rnd16(), 0);
      step();
      if (k >= 3 && k <= 6) begin
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL mrst_valid[%0d] got %b want 0", k, bus.o_valid); end
        checks++; if (int'(bus.o_c_i) !== 0 || int'(bus.o_c_q) !== 0) begin errors++; $display("FAIL mrst_data[%0d] got %0d,%0d want 0,0", k, bus.o_c_i, bus.o_c_q); end
        checks++; if (bus.o_sat !== 1'b0 || int'(bus.o_sat_cnt) !== 0) begin errors++; $display("FAIL mrst_sat[%0d] got %b,%0d want 0,0", k, bus.o_sat, bus.o_sat_cnt); end
      end
      if (k == 7) begin
        checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("FAIL mrst_new_valid got %b want 1", bus.o_valid); end
        checks++; if (int'(bus.o_c_i) !== 8192 || int'(bus.o_c_q) !== 8192) begin errors++; $display("FAIL mrst_new_data got %0d,%0d want 8192,8192", bus.o_c_i, bus.o_c_q); end
      end
      if (k == 8) begin
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL mrst_single got %b want 0", bus.o_valid); end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    test_reset();
    test_directed();
    test_back_to_back_random();
    test_sat_counter();
    test_sat_clr();
    test_midstream_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/modem_cmult_pipe.md
MODEM_CMULT_PIPE -- requirements
Module: modem_cmult_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 16, signed input component width.
REQ-002 SHALL have parameter OUT_W, default 16, signed output component width.
REQ-003 SHALL have parameter SHIFT, default 15, number of LSBs removed by rounding (0 <= SHIFT <= 2*DATA_W).
REQ-004 SHALL have parameter CNT_W, default 16, saturation counter width.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port i_valid, input, 1, marks a valid input sample.
REQ-008 SHALL have port i_conj, input, 1, per-sample mode: 0 = a*b, 1 = a*conj(b) form below.
REQ-009 SHALL have ports i_a_i, i_a_q, i_b_i, i_b_q, input, DATA_W each, signed operand components.
REQ-010 SHALL have port o_valid, output, 1, marks a valid result.
REQ-011 SHALL have ports o_c_i, o_c_q, output, OUT_W each, signed rounded and saturated result.
REQ-012 SHALL have port o_sat, output, 1, high with o_valid when either output component saturated.
REQ-013 SHALL have port o_sat_cnt, output, CNT_W, count of saturated results since reset.
REQ-014 SHALL have port i_sat_clr, input, 1, synchronous clear of o_sat_cnt.

Function
REQ-015 SHALL compute, for i_conj=0: c.i = a.i*b.i - a.q*b.q, c.q = a.q*b.i + a.i*b.q.
REQ-016 SHALL compute, for i_conj=1: c.i = a.i*b.i + a.q*b.q, c.q = a.q*b.i - a.i*b.q.
REQ-017 SHALL hold full-precision products at 2*DATA_W bits and sums at 2*DATA_W+1 bits, with no intermediate truncation.
REQ-018 SHALL be a 4-stage pipeline: S1 input register, S2 four products, S3 add/subtract, S4 round and saturate.
REQ-019 SHALL assert o_valid exactly 4 cycles after the i_valid that produced it, accept one sample per cycle, and have no backpressure.
REQ-020 SHALL carry i_conj alongside its sample through the pipeline, so back-to-back samples of mixed mode are each computed in their own mode.
REQ-021 SHALL round each sum as sum / 2^SHIFT, half away from zero: +0.5 rounds up, -0.5 rounds down (to -1); SHIFT=0 passes the value through unchanged.
REQ-022 SHALL saturate each rounded value to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-023 SHALL assert o_sat for a result if either component clipped.
REQ-024 SHALL increment o_sat_cnt by 1 for each result with o_sat=1 and hold it at all-ones with no wrap-around.
REQ-025 SHALL give i_sat_clr priority over increment: if both occur in the same cycle, the counter becomes 0.
REQ-026 SHALL register o_c_i, o_c_q and o_sat only when the stage-4 valid is high, and hold their last values otherwise.
REQ-027 SHALL ignore data and conj inputs while i_valid=0, and never produce spurious o_valid from them.

Reset
REQ-028 SHALL, on reset, clear all pipeline valid bits, o_valid, o_sat, o_c_i, o_c_q and o_sat_cnt to 0 in the cycle after reset is sampled high.
REQ-029 SHALL discard samples in flight when reset is asserted mid-stream, with no o_valid for them after reset deasserts.
REQ-030 SHALL accept a new sample with i_valid in the first cycle after reset deasserts, and present its result 4 cycles later.

Verification (DATA_W=16, OUT_W=16, SHIFT=15)
REQ-031 SHALL pass: a=(16384,0), b=(16384,16384), conj=0 -> 4 cycles later c=(8192,8192), o_sat=0.
REQ-032 SHALL pass: a=(0,16384), b=(0,16384), conj=1 then same operands conj=0 back-to-back -> c=(8192,0) then c=(-8192,0) on consecutive cycles.
REQ-033 SHALL pass: a=(1,0), b=(16384,0) -> c.i=1; a=(-1,0), b=(16384,0) -> c.i=-1 (half away from zero).
REQ-034 SHALL pass: a=(-32768,0), b=(-32768,0) -> c.i=32767, o_sat=1, o_sat_cnt=1; 70000 further such results -> o_sat_cnt holds at 65535.
REQ-035 SHALL pass: i_sat_clr coincident with a saturating result -> o_sat_cnt=0.
REQ-036 SHALL pass: 3 valid samples, then reset for 1 cycle -> o_valid stays 0 and all outputs are 0 until a new sample is sent.
